weight_buf_streamer: RTL and testbench

WEIGHT_BUF_STREAMER -- requirements
Module: weight_buf_streamer

---
 rtl/weight_buf_streamer.sv | 112 +++++++++++
 tb/tb_weight_buf_streamer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_buf_streamer.sv
// Burst streamer over an inferred dual-port weight RAM: a load port fills memory and
// a ready/valid read engine delivers rd_len consecutive words through a 2-entry buffer.
module weight_buf_streamer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W:0]   rd_len,
    output logic              rd_busy,
    output logic              rd_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   len_q, issued, accepted;
    logic              inflight;
    logic [DATA_W-1:0] fifo [2];
    logic              wp, rp;
    logic [1:0]        cnt;
    logic [2:0]        occ;
    logic              issue, pop, push, start, final_beat;

    assign start      = (state == IDLE) && rd_start;
    assign pop        = out_valid && out_ready;
    assign push       = inflight;
    assign final_beat = (accepted == len_q - (ADDR_W+1)'(1));
    // Occupancy counts the word leaving this cycle as already gone, so a
    // continuously-ready sink sees one beat per cycle.
    assign occ   = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
    assign issue = (state == STREAM) && (issued != len_q) && (occ < 3'd2);

    // Read-first: the registered read sees the array before this edge's write.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (issue) rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_start) state_nxt = (rd_len == '0) ? FINISH : STREAM;
            STREAM:  if (pop && final_beat) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr  <= '0;
            len_q    <= '0;
            issued   <= '0;
            accepted <= '0;
            inflight <= 1'b0;
            fifo[0]  <= '0;
            fifo[1]  <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            cnt      <= '0;
        end else if (start) begin
            rd_addr  <= rd_base;
            len_q    <= rd_len;
            issued   <= '0;
            accepted <= '0;
            inflight <= 1'b0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            cnt      <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                rd_addr <= rd_addr + 1'b1;
                issued  <= issued + 1'b1;
            end
            if (push) begin
                fifo[wp] <= rd_q;
                wp       <= ~wp;
            end
            if (pop) begin
                rp       <= ~rp;
                accepted <= accepted + 1'b1;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rd_busy   = (state != IDLE);
    assign rd_done   = (state == FINISH);
    assign out_valid = (state == STREAM) && (cnt != 2'd0);
    assign out_data  = fifo[rp];
    assign out_last  = out_valid && final_beat;
endmodule

// File: tb/tb_weight_buf_streamer.sv
// Directed bench for weight_buf_streamer: bursts, wrap, stalls, zero length,
// read-first collision, mid-burst reset and a full-memory sweep.
module tb_weight_buf_streamer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        rd_start = 1'b0;
    logic [10:0] rd_base = '0;
    logic [11:0] rd_len = '0;
    logic        rd_busy, rd_done, out_valid, out_last;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] beats[$];
    bit         lasts[$];
    int done_cyc, first_vcyc, hold_bad, vld_cnt;

    weight_buf_streamer #(.DATA_W(8), .ADDR_W(11)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_busy(rd_busy),
        .rd_done(rd_done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [10:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Runs one burst from the current negedge; mode 1 toggles out_ready, mode 2
    // keeps firing a competing rd_start while the burst runs.
    task automatic stream(input logic [10:0] base, input logic [11:0] len,
                          input int mode, input int budget);
        bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic pv, pr, pl;
        logic [7:0] pd;
        beats.delete(); lasts.delete();
        done_cyc = -1; first_vcyc = -1; hold_bad = 0; vld_cnt = 0;
        pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0;
        rd_start = 1'b1; rd_base = base; rd_len = len; out_ready = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            rd_start = (mode == 2) && (c <= 4);
            if (mode == 2) begin rd_base = 11'd10; rd_len = 12'd1; end
            out_ready = (mode == 1) ? pat[c % 6] : 1'b1;
            if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) hold_bad++;
            if (out_valid) begin
                vld_cnt++;
                if (first_vcyc < 0) first_vcyc = c;
            end
            if (out_valid && out_ready) begin
                beats.push_back(out_data);
                lasts.push_back(out_last);
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            if (rd_done) begin done_cyc = c; break; end
        end
        rd_start = 1'b0; out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        nvec++;
        if ({rd_busy, rd_done, out_valid, out_last, out_data} !== 12'h0) begin
            nerr++; $display("FAIL reset_state got %h want 000", {rd_busy, rd_done, out_valid, out_last, out_data});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) wr(11'(i), 8'(i));
        stream(11'd4, 12'd6, 0, 30);
        nvec++;
        if (beats.size() != 6) begin nerr++; $display("FAIL basic_count got %0d want 6", beats.size()); end
        for (int i = 0; i < beats.size() && i < 6; i++) begin
            nvec++;
            if (beats[i] !== 8'(4 + i) || lasts[i] !== (i == 5)) begin
                nerr++; $display("FAIL basic_beat%0d got %h/%b want %h/%b", i, beats[i], lasts[i], 8'(4 + i), (i == 5));
            end
        end
        nvec++;
        if (first_vcyc != 3) begin nerr++; $display("FAIL basic_latency got %0d want 3", first_vcyc); end
        nvec++;
        if (done_cyc != 9) begin nerr++; $display("FAIL basic_done got %0d want 9", done_cyc); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp[4] = '{8'hE0, 8'hE1, 8'h00, 8'h01};
        wr(11'd2046, 8'hE0);
        wr(11'd2047, 8'hE1);
        stream(11'd2046, 12'd4, 0, 30);
        nvec++;
        if (beats.size() != 4) begin nerr++; $display("FAIL wrap_count got %0d want 4", beats.size()); end
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            nvec++;
            if (beats[i] !== exp[i]) begin nerr++; $display("FAIL wrap_beat%0d got %h want %h", i, beats[i], exp[i]); end
        end
    endtask

    task automatic test_stall();
        stream(11'd0, 12'd6, 1, 60);
        nvec++;
        if (beats.size() != 6) begin nerr++; $display("FAIL stall_count got %0d want 6", beats.size()); end
        for (int i = 0; i < beats.size() && i < 6; i++) begin
            nvec++;
            if (beats[i] !== 8'(i) || lasts[i] !== (i == 5)) begin
                nerr++; $display("FAIL stall_beat%0d got %h/%b want %h/%b", i, beats[i], lasts[i], 8'(i), (i == 5));
            end
        end
        nvec++;
        if (hold_bad != 0) begin nerr++; $display("FAIL stall_hold got %0d unstable cycles want 0", hold_bad); end
        nvec++;
        if (done_cyc < 0) begin nerr++; $display("FAIL stall_done got timeout want rd_done"); end
    endtask

    task automatic test_len0_and_ignore();
        stream(11'd3, 12'd0, 0, 10);
        nvec++;
        if (done_cyc != 1) begin nerr++; $display("FAIL len0_done got %0d want 1", done_cyc); end
        nvec++;
        if (vld_cnt != 0) begin nerr++; $display("FAIL len0_valid got %0d want 0", vld_cnt); end
        stream(11'd0, 12'd4, 2, 30);
        nvec++;
        if (beats.size() != 4 || done_cyc != 7) begin
            nerr++; $display("FAIL ignore_start got %0d beats done@%0d want 4 done@7", beats.size(), done_cyc);
        end
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            nvec++;
            if (beats[i] !== 8'(i)) begin nerr++; $display("FAIL ignore_beat%0d got %h want %h", i, beats[i], 8'(i)); end
        end
    endtask

    task automatic test_read_first();
        rd_start = 1'b1; rd_base = 11'd5; rd_len = 12'd1;
        @(negedge clk);
        rd_start = 1'b0;
        wr_en = 1'b1; wr_addr = 11'd5; wr_data = 8'hAA;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 8'h05 || out_last !== 1'b1) begin
            nerr++; $display("FAIL rdfirst_old got v%b %h l%b want v1 05 l1", out_valid, out_data, out_last);
        end
        @(negedge clk);
        nvec++;
        if (rd_done !== 1'b1) begin nerr++; $display("FAIL rdfirst_done got %b want 1", rd_done); end
        @(negedge clk);
        stream(11'd5, 12'd1, 0, 10);
        nvec++;
        if (beats.size() != 1 || beats[0] !== 8'hAA) begin
            nerr++; $display("FAIL rdfirst_new got %0d beats first %h want 1 beat AA", beats.size(), beats.size() ? beats[0] : 8'h00);
        end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        int dn = 0;
        rd_start = 1'b1; rd_base = 11'd0; rd_len = 12'd8; out_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            rd_start = 1'b0;
            if (out_valid && out_ready) got++;
            if (got == 3) break;
        end
        nvec++;
        if (got != 3) begin nerr++; $display("FAIL rstmid_progress got %0d beats want 3", got); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if ({rd_busy, rd_done, out_valid, out_last, out_data} !== 12'h0) begin
            nerr++; $display("FAIL rstmid_outputs got %h want 000", {rd_busy, rd_done, out_valid, out_last, out_data});
        end
        repeat (3) begin
            @(negedge clk);
            if (rd_done) dn++;
        end
        nvec++;
        if (dn != 0) begin nerr++; $display("FAIL rstmid_nodone got %0d pulses want 0", dn); end
        rst_n = 1'b1;
        stream(11'd4, 12'd3, 0, 20);
        nvec++;
        if (beats.size() != 3 || first_vcyc != 3) begin
            nerr++; $display("FAIL rstmid_restart got %0d beats first@%0d want 3 first@3", beats.size(), first_vcyc);
        end
        for (int i = 0; i < beats.size() && i < 3; i++) begin
            nvec++;
            if (beats[i] !== ((i == 1) ? 8'hAA : 8'(4 + i))) begin
                nerr++; $display("FAIL rstmid_beat%0d got %h want %h", i, beats[i], (i == 1) ? 8'hAA : 8'(4 + i));
            end
        end
    endtask

    task automatic test_full();
        int nl = 0;
        stream(11'd0, 12'd2048, 0, 2200);
        nvec++;
        if (beats.size() != 2048 || done_cyc < 0) begin
            nerr++; $display("FAIL full_count got %0d beats done@%0d want 2048 with done", beats.size(), done_cyc);
        end else begin
            foreach (lasts[i]) if (lasts[i]) nl++;
            nvec++;
            if (nl != 1 || lasts[2047] !== 1'b1) begin
                nerr++; $display("FAIL full_last got %0d lasts final %b want 1 final 1", nl, lasts[2047]);
            end
            nvec++;
            if (beats[15] !== 8'h0F || beats[2046] !== 8'hE0 || beats[2047] !== 8'hE1) begin
                nerr++; $display("FAIL full_data got %h %h %h want 0f e0 e1", beats[15], beats[2046], beats[2047]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_len0_and_ignore();
        test_read_first();
        test_reset_mid();
        test_full();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
